// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and descriptor-op enumeration, matching the decoder.
// Small field-packing helpers are shared by the encoder datapath.
package mips_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_ADDU    = 4'd1,
    OP_SUBU    = 4'd2,
    OP_AND     = 4'd3,
    OP_OR      = 4'd4,
    OP_SLTU    = 4'd5,
    OP_LW      = 4'd6,
    OP_SW      = 4'd7,
    OP_BEQ     = 4'd8,
    OP_BLTZ    = 4'd9,
    OP_ADDIU   = 4'd10,
    OP_J       = 4'd11,
    OP_LUI     = 4'd12,
    OP_ORI     = 4'd13,
    OP_LI      = 4'd14,
    OP_ILLEGAL = 4'd15
  } in_op_e;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_J      = 6'b000010;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_ADDIU  = 6'b001001;
  localparam logic [5:0] OPC_ORI    = 6'b001101;
  localparam logic [5:0] OPC_LUI    = 6'b001111;
  localparam logic [5:0] OPC_LW     = 6'b100011;
  localparam logic [5:0] OPC_SW     = 6'b101011;

  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one symbolic op plus fields -> 32-bit MIPS word.
// LI never reaches here; the encoder splits it into LUI/ORI first.
module instr_pack
  import mips_pkg::*;
(
  input  in_op_e      op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word
);

  // Field packing per op
  always_comb begin
    word = 32'h0000_0000;
    case (op)
      OP_NOP:   word = 32'h0000_0000;
      OP_ADDU:  word = pack_r(rs, rt, rd, FUNCT_ADDU);
      OP_SUBU:  word = pack_r(rs, rt, rd, FUNCT_SUBU);
      OP_AND:   word = pack_r(rs, rt, rd, FUNCT_AND);
      OP_OR:    word = pack_r(rs, rt, rd, FUNCT_OR);
      OP_SLTU:  word = pack_r(rs, rt, rd, FUNCT_SLTU);
      OP_LW:    word = pack_i(OPC_LW, rs, rt, imm[15:0]);
      OP_SW:    word = pack_i(OPC_SW, rs, rt, imm[15:0]);
      OP_BEQ:   word = pack_i(OPC_BEQ, rs, rt, imm[15:0]);
      OP_BLTZ:  word = pack_i(OPC_REGIMM, rs, 5'd0, imm[15:0]);
      OP_ADDIU: word = pack_i(OPC_ADDIU, rs, rt, imm[15:0]);
      OP_J:     word = {OPC_J, imm};
      OP_LUI:   word = pack_i(OPC_LUI, 5'd0, rt, imm[15:0]);
      OP_ORI:   word = pack_i(OPC_ORI, rs, rt, imm[15:0]);
      default:  word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: accepts descriptors, packs them and writes them
// sequentially into instruction memory, expanding LI into LUI/ORI.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT2, ST_FULL} state_e;

  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_r;
  logic [ADDR_W:0]     count_r;
  logic [4:0]          rt2_r;
  logic [15:0]         lo2_r;

  in_op_e              op_s;
  logic                accept_s;
  logic [31:0]         offset_s;
  logic                branch_ok_s;
  logic                li_two_s;
  logic                last_slot_s;
  logic                reject_s;
  in_op_e              pk_op_s;
  logic [4:0]          pk_rs_s;
  logic [4:0]          pk_rt_s;
  logic [4:0]          pk_rd_s;
  logic [25:0]         pk_imm_s;
  logic [31:0]         pk_word_s;

  assign op_s        = in_op_e'(in_op);
  assign in_ready    = (state_r == ST_IDLE) & ~restart;
  assign accept_s    = in_valid & in_ready;
  assign offset_s    = in_imm - (32'(count_r) + 32'd1);
  // Offset fits in 16 signed bits when bits [31:15] are all sign copies
  assign branch_ok_s = (offset_s[31:15] == 17'h00000) || (offset_s[31:15] == 17'h1FFFF);
  assign li_two_s    = (in_imm[31:16] != 16'h0000) && (in_imm[15:0] != 16'h0000);
  assign last_slot_s = (count_r == LAST_SLOT);
  assign count       = count_r;

  // Descriptor rejection: illegal op, unreachable branch, LI that cannot fit
  always_comb begin
    reject_s = 1'b0;
    case (op_s)
      OP_ILLEGAL:      reject_s = 1'b1;
      OP_BEQ, OP_BLTZ: reject_s = ~branch_ok_s;
      OP_LI:           reject_s = li_two_s & last_slot_s;
      default:         reject_s = 1'b0;
    endcase
  end

  // Packer input selection: pending ORI in EMIT2, otherwise the live descriptor
  always_comb begin
    pk_op_s  = op_s;
    pk_rs_s  = in_rs;
    pk_rt_s  = in_rt;
    pk_rd_s  = in_rd;
    pk_imm_s = {10'd0, in_imm[15:0]};
    if (state_r == ST_EMIT2) begin
      pk_op_s  = OP_ORI;
      pk_rs_s  = rt2_r;
      pk_rt_s  = rt2_r;
      pk_rd_s  = 5'd0;
      pk_imm_s = {10'd0, lo2_r};
    end else begin
      case (op_s)
        OP_BEQ, OP_BLTZ: pk_imm_s = {10'd0, offset_s[15:0]};
        OP_J:            pk_imm_s = in_imm[25:0];
        OP_LI: begin
          pk_rs_s = 5'd0;
          if (in_imm[31:16] == 16'h0000) begin
            pk_op_s  = OP_ORI;
            pk_imm_s = {10'd0, in_imm[15:0]};
          end else begin
            pk_op_s  = OP_LUI;
            pk_imm_s = {10'd0, in_imm[31:16]};
          end
        end
        default:         pk_op_s = op_s;
      endcase
    end
  end

  instr_pack u_pack (
    .op   (pk_op_s),
    .rs   (pk_rs_s),
    .rt   (pk_rt_s),
    .rd   (pk_rd_s),
    .imm  (pk_imm_s),
    .word (pk_word_s)
  );

  // Loader FSM, write pointer and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      rt2_r      <= 5'd0;
      lo2_r      <= 16'h0000;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      full       <= 1'b0;
      err        <= 1'b0;
    end else if (restart) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (reject_s) begin
              err <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= count_r[ADDR_W-1:0];
              imem_wdata <= pk_word_s;
              count_r    <= count_r + CNT_ONE;
              if ((op_s == OP_LI) && li_two_s) begin
                state_r <= ST_EMIT2;
                rt2_r   <= in_rt;
                lo2_r   <= in_imm[15:0];
              end else if (last_slot_s) begin
                state_r <= ST_FULL;
                full    <= 1'b1;
              end else begin
                state_r <= ST_IDLE;
              end
            end
          end
        end
        ST_EMIT2: begin
          imem_we    <= 1'b1;
          imem_addr  <= count_r[ADDR_W-1:0];
          imem_wdata <= pk_word_s;
          count_r    <= count_r + CNT_ONE;
          if (last_slot_s) begin
            state_r <= ST_FULL;
            full    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FULL: state_r <= ST_FULL;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
